// File: rtl/dcache_wb_buffer_pkg.sv
// Shared types for the dcache write-back store buffer.
// Optional feature macro: WB_COALESCE_EN (merge a store into an already buffered line).
`ifndef DATA_SIZE
`define DATA_SIZE 64
`endif
`ifndef NUM_MEM_TAGS
`define NUM_MEM_TAGS 15
`endif

package dcache_wb_buffer_pkg;

    localparam int DATA_W = `DATA_SIZE;
    localparam int TAG_W  = $clog2(`NUM_MEM_TAGS);
    localparam int LINE_W = 29;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef struct packed {
        logic [LINE_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        DONE
    } wb_state_t;

endpackage

// File: rtl/dcache_wb_buffer_wb_fifo.sv
// Store-buffer storage: circular FIFO of line entries with valid bits and a
// parallel line-address compare against every valid slot.
module wb_fifo
    import dcache_wb_buffer_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      push,
    input  wb_entry_t                 push_entry,
    input  logic                      pop,
    input  logic [LINE_W-1:0]         match_addr,
    input  logic                      overwrite,
    input  logic [DEPTH-1:0]          overwrite_sel,
    input  logic [DATA_W-1:0]         overwrite_data,
    output wb_entry_t                 head,
    output logic [$clog2(DEPTH)-1:0]  head_ptr,
    output logic [DEPTH-1:0]          match,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PW = $clog2(DEPTH);

    wb_entry_t         entries [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [PW-1:0]     tail_ptr;

    // Payload storage carries no reset; the valid bits decide what is live.
    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push && tail_ptr == PW'(i)) begin
                entries[i] <= push_entry;
            end else if (overwrite && overwrite_sel[i]) begin
                entries[i].data <= overwrite_data;
            end
        end
    end

    // Pointers are PW bits wide so they wrap naturally modulo DEPTH.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            valid    <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                tail_ptr <= tail_ptr + 1'b1;
            end
            if (pop) begin
                head_ptr <= head_ptr + 1'b1;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (pop && head_ptr == PW'(i)) begin
                    valid[i] <= 1'b0;
                end
                if (push && tail_ptr == PW'(i)) begin
                    valid[i] <= 1'b1;
                end
            end
            count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end

    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = valid[i] && (entries[i].addr == match_addr);
        end
    end

    assign head  = entries[head_ptr];
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/dcache_wb_buffer.sv
// Write-back store buffer between the dcache and memory: stores are absorbed
// locally, loads bypass unless they hit a buffered line. Optional macro: WB_COALESCE_EN.
module dcache_wb_buffer
    import dcache_wb_buffer_pkg::*;
#(
    parameter int WB_DEPTH        = 4,
    parameter int WB_STARVE_LIMIT = 8
)
(
    input  logic                              clock,
    input  logic                              reset,
    input  BUS_COMMAND                        dc_command,
    input  logic [31:0]                       dc_addr,
    input  logic [`DATA_SIZE-1:0]             dc_data,
    output logic [$clog2(`NUM_MEM_TAGS)-1:0]  dc_response,
    output logic [`DATA_SIZE-1:0]             dc_rdata,
    output logic [$clog2(`NUM_MEM_TAGS)-1:0]  dc_tag,
    output BUS_COMMAND                        proc2mem_command,
    output logic [31:0]                       proc2mem_addr,
    output logic [`DATA_SIZE-1:0]             proc2mem_data,
    input  logic [$clog2(`NUM_MEM_TAGS)-1:0]  mem2proc_response,
    input  logic [`DATA_SIZE-1:0]             mem2proc_data,
    input  logic [$clog2(`NUM_MEM_TAGS)-1:0]  mem2proc_tag,
    input  logic                              flush_req,
    output logic                              flush_done,
    output logic [$clog2(WB_DEPTH):0]         wb_count
);

    localparam int SW = $clog2(WB_STARVE_LIMIT + 1);

    wb_state_t                  state, state_next;
    logic [SW-1:0]              starve_cnt;
    wb_entry_t                  head, push_entry;
    logic [$clog2(WB_DEPTH)-1:0] head_ptr;
    logic [WB_DEPTH-1:0]        match, coal_sel;
    logic                       full, empty;
    logic                       push, pop, overwrite;
    logic                       hazard, forced, load_go, present, coal_hit, store_ok;

    assign push_entry = '{addr: dc_addr[31:3], data: dc_data};

    wb_fifo #(.DEPTH(WB_DEPTH)) u_fifo (
        .clock          (clock),
        .reset          (reset),
        .push           (push),
        .push_entry     (push_entry),
        .pop            (pop),
        .match_addr     (dc_addr[31:3]),
        .overwrite      (overwrite),
        .overwrite_sel  (coal_sel),
        .overwrite_data (dc_data),
        .head           (head),
        .head_ptr       (head_ptr),
        .match          (match),
        .full           (full),
        .empty          (empty),
        .count          (wb_count)
    );

    // Bus arbitration: forced drain, then clean load, then ordinary drain.
    // Everything is gated by reset so the outputs go idle the moment it asserts.
    always_comb begin
        hazard   = |match;
        forced   = !empty && (starve_cnt >= SW'(WB_STARVE_LIMIT));
        load_go  = reset && (state == RUN) && (dc_command == BUS_LOAD) && !hazard && !forced;
        present  = reset && !empty && (forced || !load_go);
        pop      = present && (mem2proc_response != '0);

        // A line leaving the buffer this cycle cannot absorb a merge.
        coal_sel = match;
        if (pop) begin
            coal_sel[head_ptr] = 1'b0;
        end
`ifdef WB_COALESCE_EN
        coal_hit = |coal_sel;
`else
        coal_hit = 1'b0;
`endif
        store_ok  = reset && (dc_command == BUS_STORE) && (state == RUN) && (coal_hit || !full);
        push      = store_ok && !coal_hit;
        overwrite = store_ok && coal_hit;

        proc2mem_command = BUS_NONE;
        proc2mem_addr    = dc_addr;
        proc2mem_data    = head.data;
        dc_response      = '0;
        if (present) begin
            proc2mem_command = BUS_STORE;
            proc2mem_addr    = {head.addr, 3'b000};
        end else if (load_go) begin
            proc2mem_command = BUS_LOAD;
        end
        if (store_ok) begin
            dc_response = TAG_W'(1);
        end else if (load_go) begin
            dc_response = mem2proc_response;
        end
    end

    assign dc_rdata = mem2proc_data;
    assign dc_tag   = mem2proc_tag;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= RUN;
            starve_cnt <= '0;
        end else begin
            state <= state_next;
            if (present || empty) begin
                starve_cnt <= '0;
            end else if (starve_cnt < SW'(WB_STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        flush_done = 1'b0;
        case (state)
            RUN:     if (flush_req) state_next = FLUSH;
            FLUSH:   if (empty) state_next = DONE;
            DONE: begin
                flush_done = reset;
                state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

endmodule

// File: tb/tb_dcache_wb_buffer.sv
// Randomized self-checking bench for dcache_wb_buffer against a queue-based
// reference model, plus directed scenarios (also under WB_COALESCE_EN).
module tb_dcache_wb_buffer;
    import dcache_wb_buffer_pkg::*;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic              clock;
    logic              reset;
    BUS_COMMAND        dc_command;
    logic [31:0]       dc_addr;
    logic [63:0]       dc_data;
    logic [3:0]        dc_response;
    logic [63:0]       dc_rdata;
    logic [3:0]        dc_tag;
    BUS_COMMAND        proc2mem_command;
    logic [31:0]       proc2mem_addr;
    logic [63:0]       proc2mem_data;
    logic [3:0]        mem2proc_response;
    logic [63:0]       mem2proc_data;
    logic [3:0]        mem2proc_tag;
    logic              flush_req;
    logic              flush_done;
    logic [2:0]        wb_count;

    dcache_wb_buffer #(.WB_DEPTH(DEPTH), .WB_STARVE_LIMIT(LIMIT)) dut (
        .clock             (clock),
        .reset             (reset),
        .dc_command        (dc_command),
        .dc_addr           (dc_addr),
        .dc_data           (dc_data),
        .dc_response       (dc_response),
        .dc_rdata          (dc_rdata),
        .dc_tag            (dc_tag),
        .proc2mem_command  (proc2mem_command),
        .proc2mem_addr     (proc2mem_addr),
        .proc2mem_data     (proc2mem_data),
        .mem2proc_response (mem2proc_response),
        .mem2proc_data     (mem2proc_data),
        .mem2proc_tag      (mem2proc_tag),
        .flush_req         (flush_req),
        .flush_done        (flush_done),
        .wb_count          (wb_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [28:0] line;
        logic [63:0] data;
    } model_entry_t;

    model_entry_t q[$];
    int           m_state;
    int           starve;
    int           check_count;
    int           error_count;
    BUS_COMMAND   last_cmd;
    logic [3:0]   last_resp;
    logic [63:0]  last_data;
    logic         last_done;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Asserts reset wherever we are in the cycle and checks outputs go idle at once.
    task automatic applyReset();
        reset = 1'b0;
        #1;
        checkOutput("rst_cmd", proc2mem_command, BUS_NONE);
        checkOutput("rst_resp", dc_response, 0);
        checkOutput("rst_count", wb_count, 0);
        checkOutput("rst_done", flush_done, 0);
        q.delete();
        m_state = 0;
        starve  = 0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    // One clock cycle: drive at the negedge, check outputs, then advance the model at the posedge.
    task automatic applyStimulus(input BUS_COMMAND cmd, input logic [31:0] addr, input logic [63:0] data,
                                 input logic [3:0] resp, input logic flush);
        int          hit_idx;
        int          size_before;
        bit          forced, load_go, present, popped, accept, coal;
        BUS_COMMAND  exp_cmd;
        logic [3:0]  exp_resp;
        model_entry_t dummy;

        dc_command        = cmd;
        dc_addr           = addr;
        dc_data           = data;
        mem2proc_response = resp;
        mem2proc_data     = {$urandom, $urandom};
        mem2proc_tag      = 4'($urandom_range(0, 15));
        flush_req         = flush;
        #1;

        hit_idx = -1;
        foreach (q[i]) if (q[i].line == addr[31:3]) hit_idx = i;
        size_before = q.size();
        forced  = size_before > 0 && starve >= LIMIT;
        load_go = m_state == 0 && cmd == BUS_LOAD && hit_idx < 0 && !forced;
        present = size_before > 0 && (forced || !load_go);
        popped  = present && resp != 0;
        coal    = 1'b0;
`ifdef WB_COALESCE_EN
        coal = hit_idx >= 0 && !(popped && hit_idx == 0);
`endif
        accept   = cmd == BUS_STORE && m_state == 0 && (coal || size_before < DEPTH);
        exp_cmd  = present ? BUS_STORE : (load_go ? BUS_LOAD : BUS_NONE);
        exp_resp = accept ? 4'd1 : (load_go ? resp : 4'd0);

        checkOutput("cmd", proc2mem_command, exp_cmd);
        checkOutput("resp", dc_response, exp_resp);
        checkOutput("count", wb_count, size_before);
        checkOutput("flush_done", flush_done, m_state == 2);
        checkOutput("rdata", dc_rdata, mem2proc_data);
        checkOutput("tag", dc_tag, mem2proc_tag);
        if (exp_cmd == BUS_STORE) begin
            checkOutput("drain_addr", proc2mem_addr, {q[0].line, 3'b000});
            checkOutput("drain_data", proc2mem_data, q[0].data);
        end else if (exp_cmd == BUS_LOAD) begin
            checkOutput("load_addr", proc2mem_addr, addr);
        end
        last_cmd  = proc2mem_command;
        last_resp = dc_response;
        last_data = proc2mem_data;
        last_done = flush_done;

        @(posedge clock);
        if (accept && coal) q[hit_idx].data = data;
        if (popped) dummy = q.pop_front();
        if (accept && !coal) q.push_back('{line: addr[31:3], data: data});
        starve = (present || size_before == 0) ? 0 : starve + 1;
        case (m_state)
            0: if (flush) m_state = 1;
            1: if (size_before == 0) m_state = 2;
            default: m_state = 0;
        endcase
        @(negedge clock);
    endtask

    initial begin
        int pulses;
        BUS_COMMAND rc;

        check_count       = 0;
        error_count       = 0;
        reset             = 1'b0;
        dc_command        = BUS_LOAD;
        dc_addr           = 32'h40;
        dc_data           = '0;
        mem2proc_response = 4'd1;
        mem2proc_data     = '0;
        mem2proc_tag      = '0;
        flush_req         = 1'b0;
        @(negedge clock);
        applyReset();

        // Fill to capacity with memory idle, then a fifth store must bounce.
        for (int k = 0; k < 4; k++) applyStimulus(BUS_STORE, 32'h100 + 32'(8 * k), 64'hA000 + 64'(k), 4'd0, 1'b0);
        checkOutput("full_count", wb_count, 4);
        applyStimulus(BUS_STORE, 32'h120, 64'hBEEF, 4'd0, 1'b0);
        checkOutput("full_reject", last_resp, 0);

        // Load hitting a buffered line waits for that line to drain.
        applyReset();
        applyStimulus(BUS_STORE, 32'h200, 64'h1234, 4'd0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(BUS_LOAD, 32'h204, 64'h0, 4'd0, 1'b0);
            checkOutput("hazard_reject", last_resp, 0);
            checkOutput("hazard_bus", last_cmd, BUS_STORE);
        end
        applyStimulus(BUS_LOAD, 32'h204, 64'h0, 4'd1, 1'b0);
        checkOutput("hazard_drain_resp", last_resp, 0);
        applyStimulus(BUS_LOAD, 32'h204, 64'h0, 4'd3, 1'b0);
        checkOutput("hazard_load_cmd", last_cmd, BUS_LOAD);
        checkOutput("hazard_load_resp", last_resp, 3);

        // Continuous loads starve the drain until the limit forces it.
        applyReset();
        applyStimulus(BUS_STORE, 32'h500, 64'h55, 4'd0, 1'b0);
        applyStimulus(BUS_STORE, 32'h508, 64'h66, 4'd0, 1'b0);
        for (int c = 1; c <= 9; c++) begin
            applyStimulus(BUS_LOAD, 32'h600, 64'h0, 4'd2, 1'b0);
            if (c < 9) begin
                checkOutput("starve_load", last_cmd, BUS_LOAD);
            end else begin
                checkOutput("forced_cmd", last_cmd, BUS_STORE);
                checkOutput("forced_reject", last_resp, 0);
            end
        end
        checkOutput("forced_count", wb_count, 1);

        // Flush with three entries and memory accepting every cycle.
        applyReset();
        for (int k = 0; k < 3; k++) applyStimulus(BUS_STORE, 32'h700 + 32'(8 * k), 64'h70 + 64'(k), 4'd0, 1'b0);
        applyStimulus(BUS_NONE, 32'h0, 64'h0, 4'd1, 1'b1);
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            applyStimulus(BUS_STORE, 32'h780, 64'h99, 4'd1, 1'b0);
            checkOutput("flush_store_reject", last_resp, 0);
            if (last_done) pulses++;
        end
        for (int c = 0; c < 2; c++) begin
            applyStimulus(BUS_NONE, 32'h0, 64'h0, 4'd0, 1'b0);
            if (last_done) pulses++;
        end
        checkOutput("flush_pulses", pulses, 1);
        checkOutput("flush_empty", wb_count, 0);
        applyStimulus(BUS_STORE, 32'h780, 64'h99, 4'd0, 1'b0);
        checkOutput("flush_back_to_run", last_resp, 1);

`ifdef WB_COALESCE_EN
        applyReset();
        applyStimulus(BUS_STORE, 32'h300, 64'hAAAA, 4'd0, 1'b0);
        applyStimulus(BUS_STORE, 32'h300, 64'hBBBB, 4'd0, 1'b0);
        checkOutput("coal_resp", last_resp, 1);
        checkOutput("coal_count", wb_count, 1);
        applyStimulus(BUS_NONE, 32'h0, 64'h0, 4'd1, 1'b0);
        checkOutput("coal_data", last_data, 64'hBBBB);
`endif

        // Reset asserted in the middle of a drain cycle, with a load also pending.
        applyReset();
        applyStimulus(BUS_STORE, 32'h800, 64'h88, 4'd0, 1'b0);
        applyStimulus(BUS_STORE, 32'h808, 64'h89, 4'd0, 1'b0);
        dc_command        = BUS_LOAD;
        dc_addr           = 32'h900;
        mem2proc_response = 4'd1;
        #3;
        applyReset();
        applyStimulus(BUS_NONE, 32'h0, 64'h0, 4'd1, 1'b0);
        checkOutput("post_reset_count", wb_count, 0);

        // Random traffic over a small set of lines to provoke hazards and wrap-around.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) applyReset();
            case ($urandom_range(0, 2))
                0:       rc = BUS_NONE;
                1:       rc = BUS_LOAD;
                default: rc = BUS_STORE;
            endcase
            applyStimulus(rc,
                          32'h400 + 32'(8 * $urandom_range(0, 7)) + 32'($urandom_range(0, 7)),
                          {$urandom, $urandom},
                          ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0,
                          $urandom_range(0, 29) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/dcache_wb_buffer.md
DCACHE_WB_BUFFER -- requirements
Module: dcache_wb_buffer

Interface
REQ-001 Parameter WB_DEPTH, default 4: store-buffer entries; power of two, minimum 2.
REQ-002 Parameter WB_STARVE_LIMIT, default 8: consecutive blocked-drain cycles before drain gets forced priority.
REQ-003 clock  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately.
REQ-005 dc_command  in  BUS_COMMAND  request from dcache_top: BUS_NONE, BUS_LOAD or BUS_STORE.
REQ-006 dc_addr  in  32  request address; bits [31:3] identify the 8-byte line.
REQ-007 dc_data  in  `DATA_SIZE  store data, a full line.
REQ-008 dc_response  out  $clog2(`NUM_MEM_TAGS)  0 means rejected; nonzero means accepted.
REQ-009 dc_rdata  out  `DATA_SIZE  returned load data.
REQ-010 dc_tag  out  $clog2(`NUM_MEM_TAGS)  returned load tag.
REQ-011 proc2mem_command, proc2mem_addr, proc2mem_data  out  BUS_COMMAND/32/`DATA_SIZE  memory request.
REQ-012 mem2proc_response, mem2proc_data, mem2proc_tag  in  as at dcache_top  memory reply.
REQ-013 flush_req  in  1  level request to drain the buffer completely.
REQ-014 flush_done  out  1  one-cycle pulse when a flush completes.
REQ-015 wb_count  out  $clog2(WB_DEPTH)+1  number of valid entries.

Function
REQ-016 Entries form a FIFO of {addr[31:3], data}, written at tail and drained from head.
REQ-017 dc_rdata and dc_tag shall combinationally equal mem2proc_data and mem2proc_tag.
REQ-018 Store accept:
- Condition: not full and state RUN.
- Action: enqueue at the clock edge.
- Response: dc_response=1 in the same cycle.
- No memory bus use.
REQ-019 Store reject: full or not RUN gives dc_response=0; no state change, and dcache retries.
REQ-020 Load clear of hazard: driven onto proc2mem_* combinationally, with dc_response=mem2proc_response.
REQ-021 Load hazard:
- Condition: dc_addr[31:3] matches any valid entry.
- Effect: the load is rejected (dc_response=0) and proc2mem_command=BUS_NONE for it.
REQ-022 Drain: head is presented as BUS_STORE (addr={head.addr,3'b0}) when the bus is not taken by a load; it is popped at the edge if mem2proc_response≠0.
REQ-023 Bus priority per cycle:
- 1. Forced drain.
- 2. Non-hazard load.
- 3. Drain.
- At most one command per cycle.
REQ-024 Starve counter:
- Increments each cycle the buffer is non-empty and the head is not presented.
- Clears on presenting the head.
- At WB_STARVE_LIMIT the next cycle is a forced drain and any load is rejected.
REQ-025 States:
- RUN: flush_req=1 goes to FLUSH.
- FLUSH: stores and loads rejected, drain only; wb_count=0 goes to DONE.
- DONE: flush_done=1 for one cycle, then RUN.
REQ-026 Simultaneous pop and push: both occur, and wb_count is unchanged.
REQ-027 Full is evaluated from registered count; a slot freed in the same cycle is not reusable until the next cycle.
REQ-028 Wrap-around: head and tail pointers wrap modulo WB_DEPTH.

Reset
REQ-029 While reset=0:
- count, pointers, entry valids and starve counter are cleared.
- State is RUN.
- flush_done=0.
- proc2mem_command=BUS_NONE.
- dc_response=0.
REQ-030 Entries in flight at reset are discarded and no drain completes.

Configuration
REQ-031 WB_COALESCE_EN defined:
- A store whose addr[31:3] matches a valid entry overwrites that entry's data, with dc_response=1, even when full.
- Addresses in the buffer remain unique.
REQ-032 WB_COALESCE_EN undefined: every accepted store allocates a new entry.

Structure
REQ-033 The shared package holds the wb_entry_t struct and the wb_state_t enum {RUN, FLUSH, DONE}.
REQ-034 One sub-module, wb_fifo: storage, pointers, count, and the parallel address-match vector.

Verification
REQ-035 Four stores to 0x100/0x108/0x110/0x118 with memory idle: wb_count=4, then a fifth store gets dc_response=0.
REQ-036 Store to 0x200, then a load from 0x204: load rejected until the drain is accepted, then the load is issued to memory.
REQ-037 Loads every cycle with 2 buffered entries and WB_STARVE_LIMIT=8: the head drains at cycle 9 and that cycle's load is rejected.
REQ-038 flush_req with 3 entries and memory accepting each cycle: stores rejected, wb_count 3→0, flush_done pulses once, state RUN.
REQ-039 WB_COALESCE_EN, stores 0x300=A then 0x300=B: wb_count=1, and the drain writes B.
REQ-040 reset=0 asynchronously mid-drain: outputs idle immediately and wb_count=0.
